cacheline_adaptor: RTL and testbench
====================================

Name: cacheline_adaptor

Overview:
- Sits directly downstream of the cache, between the cache's 256-bit physical-memory port and the 64-bit burst memory.
- Converts one cacheline read or write into a 4-beat burst transaction.
- Presents a single-cycle completion pulse back to the cache.
- Line side connects to cache pmem_* signals; burst side connects to the burst DRAM model.

Parameters:
- s_line, 256, cacheline width in bits.
- s_burst, 64, burst beat width in bits.
- s_offset, 5, line-offset bits cleared on the outgoing address.
- Derived: beats = s_line/s_burst = 4; counter width = clog2(beats) = 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- line_i  input  256  write line from cache (pmem_wdata).
- line_o  output  256  assembled read line to cache (pmem_rdata).
- address_i  input  32  line address from cache (pmem_address).
- read_i  input  1  line read request (pmem_read).
- write_i  input  1  line write request (pmem_write).
- resp_o  output  1  transaction complete, one-cycle pulse (pmem_resp).
- burst_i  input  64  read beat from memory.
- burst_o  output  64  write beat to memory.
- address_o  output  32  burst address to memory.
- read_o  output  1  burst read request.
- write_o  output  1  burst write request.
- resp_i  input  1  beat valid/accepted from memory.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous, active-high.
- Reset values: state IDLE, count 0, line_o 0, address_o 0, burst_o 0, read_o/write_o/resp_o 0, line buffer 0. Reset asserted mid-transaction aborts immediately; no further beats consumed, and no resp_o is issued.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - read_i=1 -> capture address_o = {address_i[31:5], 5'b0}, count=0, go READ.
  - Otherwise write_i=1 -> capture address as above, latch line_i into line buffer, count=0, go WRITE.
  - read_i and write_i both high -> read wins.
  - resp_i in IDLE is ignored.
- READ:
  - read_o=1, address_o held.
  - On each cycle with resp_i=1: line_o[64*count +: 64] <= burst_i; count++.
  - Beats may be non-contiguous; resp_i low stalls with no state change.
  - Beat with count==3 -> go DONE.
  - Beat 0 maps to line bits [63:0].
- WRITE:
  - write_o=1, address_o held.
  - burst_o = buffer[64*count +: 64], combinational from count.
  - On each resp_i=1: count++. Beat with count==3 -> go DONE.
- DONE:
  - resp_o=1 for exactly one cycle; read_o/write_o=0; go IDLE.
  - line_o stays stable until overwritten by the next READ beat.
- Latency: request sampled in IDLE at cycle N; read_o/write_o high at N+1; resp_o high the cycle after the 4th beat.
  - Minimum latency, back-to-back resp_i: request at N, beats N+1..N+4, resp_o at N+5.
- Request inputs are sampled only in IDLE. Changes to read_i, write_i, address_i or line_i during READ/WRITE/DONE are ignored; the in-flight transaction completes unchanged.
- The cache must deassert its request in the cycle after resp_o. A request still high in IDLE starts a new transaction.
- Count wraps 3->0 on the DONE transition; there is no overflow path.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, no read_o/write_o.
- Read at address_i=0x0000_1234; memory returns beats 0x1111..., 0x2222..., 0x3333..., 0x4444... on consecutive cycles.
  - Required: address_o=0x0000_1220, read_o high 4 cycles.
  - Required: line_o={0x4444..,0x3333..,0x2222..,0x1111..}, resp_o single pulse 5 cycles after request.
- Write line_i=0xDDDD..CCCC..BBBB..AAAA.. with resp_i gapped (1,0,1,0,1,1).
  - Required: burst_o sequence AAAA, BBBB, CCCC, DDDD, advancing only on resp_i=1.
  - Required: write_o held through the gaps; resp_o after the 4th accepted beat.
- read_i=write_i=1 simultaneously -> READ performed, write_o never asserted.
- rst asserted after 2 read beats -> next cycle IDLE, read_o=0, line_o=0, no resp_o; a new read then completes normally.
- address_i changed and read_i dropped mid-read -> address_o unchanged, all 4 beats taken, resp_o still pulses once.

Source files
------------

// File: rtl/cacheline_adaptor.sv
// Bridges a 256-bit cacheline port to a 64-bit, 4-beat burst memory port.
// One line read or write becomes one burst, followed by a single-cycle resp_o.
module cacheline_adaptor #(
  parameter int s_line   = 256,
  parameter int s_burst  = 64,
  parameter int s_offset = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int beats = s_line / s_burst;
  localparam int cw    = $clog2(beats);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [cw-1:0]     count;
  logic [s_line-1:0] buffer;
  logic [31:0]       line_addr;
  logic              last_beat;

  always_comb begin
    line_addr                 = address_i;
    line_addr[s_offset-1:0]   = '0;
  end

  assign last_beat = (count == cw'(beats - 1));

  // State register plus the datapath registers that move with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      line_o    <= '0;
      address_o <= '0;
      buffer    <= '0;
    end else begin
      state <= state_next;
      unique case (state)
        IDLE: begin
          if (read_i || write_i) begin
            address_o <= line_addr;
            count     <= '0;
          end
          if (!read_i && write_i) begin
            buffer <= line_i;
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[s_burst*int'(count) +: s_burst] <= burst_i;
            count <= count + 1'b1;
          end
        end
        WRITE: begin
          if (resp_i) begin
            count <= count + 1'b1;
          end
        end
        DONE: begin
          count <= '0;
        end
        default: begin
          count <= '0;
        end
      endcase
    end
  end

  // Next-state logic: read has priority over write when both are requested.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (read_i) begin
          state_next = READ;
        end else if (write_i) begin
          state_next = WRITE;
        end
      end
      READ: begin
        if (resp_i && last_beat) begin
          state_next = DONE;
        end
      end
      WRITE: begin
        if (resp_i && last_beat) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_comb begin
    read_o  = 1'b0;
    write_o = 1'b0;
    resp_o  = 1'b0;
    burst_o = '0;
    unique case (state)
      IDLE: begin
        burst_o = '0;
      end
      READ: begin
        read_o = 1'b1;
      end
      WRITE: begin
        write_o = 1'b1;
        burst_o = buffer[s_burst*int'(count) +: s_burst];
      end
      DONE: begin
        resp_o = 1'b1;
      end
      default: begin
        burst_o = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: a transaction-level model is compared
// against the DUT every cycle, alongside hand-computed literal checks.
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_adaptor #(.s_line(256), .s_burst(64), .s_offset(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] W1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] W2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] W3 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] W4 = 64'h4444_4444_4444_4444;
  localparam logic [63:0] WA = 64'hAAAA_AAAA_AAAA_AAAA;
  localparam logic [63:0] WB = 64'hBBBB_BBBB_BBBB_BBBB;
  localparam logic [63:0] WC = 64'hCCCC_CCCC_CCCC_CCCC;
  localparam logic [63:0] WD = 64'hDDDD_DDDD_DDDD_DDDD;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  function automatic void chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Transaction-level model: one pending line request, beats accepted so far,
  // then a one-cycle completion.
  bit           m_active;
  bit           m_is_read;
  bit           m_resp;
  int           m_beats;
  logic [31:0]  m_addr;
  logic [255:0] m_rline;
  logic [255:0] m_wline;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 0; m_is_read = 0; m_resp = 0; m_beats = 0;
      m_addr = '0; m_rline = '0; m_wline = '0;
    end else if (m_resp) begin
      m_resp = 0;
    end else if (m_active) begin
      if (resp_i) begin
        if (m_is_read) m_rline[64*m_beats +: 64] = burst_i;
        m_beats++;
        if (m_beats == 4) begin
          m_active = 0;
          m_resp   = 1;
        end
      end
    end else if (read_i || write_i) begin
      m_active  = 1;
      m_is_read = read_i;
      m_beats   = 0;
      m_addr    = address_i & 32'hFFFF_FFE0;
      if (!read_i) m_wline = line_i;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_read_o",    {255'd0, read_o},  {255'd0, m_active && m_is_read});
      chk("m_write_o",   {255'd0, write_o}, {255'd0, m_active && !m_is_read});
      chk("m_resp_o",    {255'd0, resp_o},  {255'd0, m_resp});
      chk("m_address_o", {224'd0, address_o}, {224'd0, m_addr});
      chk("m_line_o",    line_o, m_rline);
      chk("m_burst_o",   {192'd0, burst_o},
          {192'd0, (m_active && !m_is_read) ? m_wline[64*m_beats +: 64] : 64'd0});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [63:0] rwords [4] = '{W1, W2, W3, W4};
  logic [63:0] wwords [4] = '{WA, WB, WC, WD};
  int          pat    [6] = '{1, 0, 1, 0, 1, 1};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    rst = 1'b1; read_i = 0; write_i = 0; resp_i = 0;
    address_i = '0; line_i = '0; burst_i = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;

    // Idle with stray resp_i: nothing moves.
    for (int i = 0; i < 10; i++) begin
      tick();
      resp_i = i[0];
      burst_i = W3;
      @(negedge clk);
      chk("idle_outputs", {251'd0, read_o, write_o, resp_o, |burst_o, |line_o}, 256'd0);
    end
    resp_i = 0;

    // Back-to-back read.
    tick();
    read_i = 1; address_i = 32'h0000_1234;
    for (int i = 0; i < 4; i++) begin
      tick();
      read_i = 0; resp_i = 1; burst_i = rwords[i];
      @(negedge clk);
      chk("rd_read_o", {255'd0, read_o}, 256'd1);
      chk("rd_addr", {224'd0, address_o}, 256'h1220);
    end
    tick();
    resp_i = 0;
    @(negedge clk);
    chk("rd_resp", {255'd0, resp_o}, 256'd1);
    chk("rd_line", line_o, {W4, W3, W2, W1});
    tick();
    @(negedge clk);
    chk("rd_resp_once", {255'd0, resp_o}, 256'd0);

    // Write with gapped acceptance.
    tick();
    write_i = 1; line_i = {WD, WC, WB, WA}; address_i = 32'h0000_2FFF;
    acc = 0;
    for (int p = 0; p < 6; p++) begin
      tick();
      write_i = 0; line_i = '0; resp_i = pat[p][0];
      @(negedge clk);
      chk("wr_burst", {192'd0, burst_o}, {192'd0, wwords[acc]});
      chk("wr_write_o", {255'd0, write_o}, 256'd1);
      if (pat[p] != 0) acc++;
    end
    tick();
    resp_i = 0;
    @(negedge clk);
    chk("wr_resp", {255'd0, resp_o}, 256'd1);
    chk("wr_addr", {224'd0, address_o}, 256'h2FE0);

    // Simultaneous read and write: read wins.
    tick();
    read_i = 1; write_i = 1; line_i = {4{W2}}; address_i = 32'h0000_0040;
    for (int i = 0; i < 4; i++) begin
      tick();
      read_i = 0; write_i = 0; resp_i = 1; burst_i = wwords[3-i];
      @(negedge clk);
      chk("dual_no_write", {255'd0, write_o}, 256'd0);
      chk("dual_read", {255'd0, read_o}, 256'd1);
    end
    tick();
    resp_i = 0;
    @(negedge clk);
    chk("dual_line", line_o, {WA, WB, WC, WD});

    // Reset after two read beats.
    tick();
    read_i = 1; address_i = 32'h0000_0100;
    for (int i = 0; i < 2; i++) begin
      tick();
      read_i = 0; resp_i = 1; burst_i = rwords[i];
    end
    tick();
    rst = 1; burst_i = W3;
    tick();
    rst = 0; resp_i = 0;
    @(negedge clk);
    chk("rst_read_o", {255'd0, read_o}, 256'd0);
    chk("rst_line", line_o, 256'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      chk("rst_no_resp", {255'd0, resp_o}, 256'd0);
    end
    tick();
    read_i = 1; address_i = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      tick();
      read_i = 0; resp_i = 1; burst_i = rwords[3-i];
    end
    tick();
    resp_i = 0;
    @(negedge clk);
    chk("rst_reread_resp", {255'd0, resp_o}, 256'd1);
    chk("rst_reread_line", line_o, {W1, W2, W3, W4});

    // Request inputs disturbed mid-read.
    tick();
    read_i = 1; address_i = 32'h8000_0047;
    acc = 0;
    for (int p = 0; p < 6; p++) begin
      tick();
      read_i = 0; address_i = 32'hFFFF_FFFF; line_i = {4{WC}};
      resp_i = pat[5-p][0]; burst_i = wwords[acc];
      @(negedge clk);
      chk("mid_addr", {224'd0, address_o}, 256'h8000_0040);
      if (pat[5-p] != 0) acc++;
    end
    tick();
    resp_i = 0;
    @(negedge clk);
    chk("mid_resp", {255'd0, resp_o}, 256'd1);
    chk("mid_line", line_o, {WD, WC, WB, WA});
    tick();
    @(negedge clk);
    chk("mid_resp_once", {255'd0, resp_o}, 256'd0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
